// File: rtl/st7735_pkg.sv
// Shared encodings for the ST7735 serial sequencer: FSM states, DC levels and
// the panel command opcodes used by drivers of this block.
package st7735_pkg;

   typedef enum logic [2:0] {
      RST_PULSE = 3'd0,
      RST_WAIT  = 3'd1,
      IDLE      = 3'd2,
      SHIFT_LO  = 3'd3,
      SHIFT_HI  = 3'd4,
      HOLD      = 3'd5,
      GAP       = 3'd6
   } seq_state_t;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam logic [7:0] SWRESET = 8'h01;
   localparam logic [7:0] SLPOUT  = 8'h11;
   localparam logic [7:0] DISPON  = 8'h29;
   localparam logic [7:0] CASET   = 8'h2A;
   localparam logic [7:0] RASET   = 8'h2B;
   localparam logic [7:0] RAMWR   = 8'h2C;

   localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/st7735_tick_gen.sv
// Down-counter that emits a one-cycle enable every DIV enabled clocks; a clear
// reloads it so the first half-period after an accept is always full length.
module st7735_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int             CW     = $clog2(DIV + 1);
   localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         cnt <= '0;
      else if (clr || tick)
         cnt <= RELOAD;
      else if (en)
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/st7735_sequencer.sv
// SPI mode-0 byte sequencer for an ST7735 panel: power-on reset pulse and wait,
// then one byte per handshake with CS held across multi-byte transactions.
module st7735_sequencer
   import st7735_pkg::*;
#(
   parameter int SPI_DIV            = 2,
   parameter int RESET_PULSE_CYCLES = 24,
   parameter int RESET_WAIT_CYCLES  = 1440000,
   parameter int CS_GAP_CYCLES      = 2
) (
   input  logic       SYSTEM_CLK,
   input  logic       SYSTEM_RESET_N,
   input  logic [7:0] IN_DATA,
   input  logic       IN_DC,
   input  logic       IN_LAST,
   input  logic       IN_VALID,
   output logic       IN_READY,
   output logic       CS,
   output logic       MOSI,
   output logic       DC,
   output logic       LCD_CLK,
   output logic       RESET,
   output logic       INIT_DONE,
   output logic       BUSY
);

   localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);
   localparam int WW = $clog2(RESET_WAIT_CYCLES + 1);
   localparam int GW = $clog2(CS_GAP_CYCLES + 1);
   localparam int BW = $clog2(BITS_PER_BYTE + 1);

   localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(RESET_WAIT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

   seq_state_t    state, state_nxt;
   logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
   logic [WW-1:0] wait_cnt, wait_cnt_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          last_q, last_nxt;
   logic          cs_nxt, mosi_nxt, dc_nxt, lclk_nxt, rst_nxt, init_nxt;
   logic          accept, tick, shifting;

   assign IN_READY = INIT_DONE && ((state == IDLE) || (state == HOLD));
   assign accept   = IN_VALID && IN_READY;
   assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);
   assign BUSY     = state inside {SHIFT_LO, SHIFT_HI, HOLD, GAP};

   st7735_tick_gen #(.DIV(SPI_DIV)) u_tick (
      .clk   (SYSTEM_CLK),
      .rst_n (SYSTEM_RESET_N),
      .clr   (accept),
      .en    (shifting),
      .tick  (tick)
   );

   always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         state     <= RST_PULSE;
         pulse_cnt <= '0;
         wait_cnt  <= '0;
         gap_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         last_q    <= 1'b0;
         CS        <= 1'b1;
         MOSI      <= 1'b0;
         DC        <= DC_CMD;
         LCD_CLK   <= 1'b0;
         RESET     <= 1'b0;
         INIT_DONE <= 1'b0;
      end else begin
         state     <= state_nxt;
         pulse_cnt <= pulse_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         last_q    <= last_nxt;
         CS        <= cs_nxt;
         MOSI      <= mosi_nxt;
         DC        <= dc_nxt;
         LCD_CLK   <= lclk_nxt;
         RESET     <= rst_nxt;
         INIT_DONE <= init_nxt;
      end
   end

   always_comb begin
      // NOTE: every target gets its hold value first, so no path through this block infers a latch.
      state_nxt     = state;
      pulse_cnt_nxt = pulse_cnt;
      wait_cnt_nxt  = wait_cnt;
      gap_cnt_nxt   = gap_cnt;
      bit_cnt_nxt   = bit_cnt;
      shreg_nxt     = shreg;
      last_nxt      = last_q;
      cs_nxt        = CS;
      mosi_nxt      = MOSI;
      dc_nxt        = DC;
      lclk_nxt      = LCD_CLK;
      rst_nxt       = RESET;
      init_nxt      = INIT_DONE;

      case (state)
         RST_PULSE: begin
            if (pulse_cnt == PULSE_LAST) begin
               rst_nxt   = 1'b1;
               state_nxt = RST_WAIT;
            end else begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end
         end
         RST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               init_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         IDLE, HOLD: begin
            if (accept) begin
               shreg_nxt   = IN_DATA;
               last_nxt    = IN_LAST;
               dc_nxt      = IN_DC;
               mosi_nxt    = IN_DATA[7];
               cs_nxt      = 1'b0;
               lclk_nxt    = 1'b0;
               bit_cnt_nxt = '0;
               state_nxt   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               lclk_nxt  = 1'b1;
               state_nxt = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               lclk_nxt = 1'b0;
               if (bit_cnt == BIT_LAST) begin
                  // The last flag decides whether CS is released or held for a follow-on byte.
                  if (last_q) begin
                     cs_nxt      = 1'b1;
                     gap_cnt_nxt = '0;
                     state_nxt   = GAP;
                  end else begin
                     state_nxt = HOLD;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  mosi_nxt    = shreg[6];
                  shreg_nxt   = {shreg[6:0], 1'b0};
                  state_nxt   = SHIFT_LO;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_nxt = IDLE;
            else
               gap_cnt_nxt = gap_cnt + 1'b1;
         end
         default: state_nxt = RST_PULSE;
      endcase
   end

endmodule

// File: tb/tb_st7735_sequencer.sv
// Randomized bench for st7735_sequencer: a timeline model derived from accept
// times predicts every output each cycle; literal checks pin the model.
module tb_st7735_sequencer;
   import st7735_pkg::*;

   localparam int DIV  = 2;
   localparam int PULS = 10;
   localparam int WAIT = 20;
   localparam int GAPC = 2;
   localparam int BYTE_CYC = 16 * DIV;

   logic       SYSTEM_CLK = 1'b0;
   logic       SYSTEM_RESET_N;
   logic [7:0] IN_DATA;
   logic       IN_DC, IN_LAST, IN_VALID;
   logic       IN_READY, CS, MOSI, DC, LCD_CLK, RESET, INIT_DONE, BUSY;

   st7735_sequencer #(
      .SPI_DIV(DIV), .RESET_PULSE_CYCLES(PULS),
      .RESET_WAIT_CYCLES(WAIT), .CS_GAP_CYCLES(GAPC)
   ) dut (
      .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N),
      .IN_DATA(IN_DATA), .IN_DC(IN_DC), .IN_LAST(IN_LAST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .CS(CS), .MOSI(MOSI), .DC(DC), .LCD_CLK(LCD_CLK), .RESET(RESET),
      .INIT_DONE(INIT_DONE), .BUSY(BUSY)
   );

   always #5 SYSTEM_CLK = ~SYSTEM_CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: everything follows from clocks since reset release and the last accept time.
   int         cyc, t_acc;
   bit         have_tx;
   logic [7:0] m_byte;
   logic       m_dc, m_last;

   function automatic int k_since();
      return cyc - t_acc;
   endfunction

   function automatic bit e_init();
      return cyc >= PULS + WAIT;
   endfunction

   function automatic bit e_shifting();
      return have_tx && (k_since() < BYTE_CYC);
   endfunction

   function automatic bit e_ready();
      if (!e_init()) return 1'b0;
      if (!have_tx) return 1'b1;
      if (k_since() < BYTE_CYC) return 1'b0;
      return !m_last || (k_since() >= BYTE_CYC + GAPC);
   endfunction

   function automatic bit e_cs();
      return !(have_tx && (k_since() < BYTE_CYC || !m_last));
   endfunction

   function automatic bit e_busy();
      return have_tx && (k_since() < BYTE_CYC || !m_last || k_since() < BYTE_CYC + GAPC);
   endfunction

   function automatic bit e_lclk();
      return e_shifting() && ((k_since() / DIV) % 2 == 1);
   endfunction

   function automatic bit e_mosi();
      int idx;
      idx = e_shifting() ? 7 - k_since() / (2 * DIV) : 0;
      return m_byte[idx];
   endfunction

   always @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         cyc <= 0; t_acc <= 0; have_tx <= 1'b0;
         m_byte <= 8'h00; m_dc <= 1'b0; m_last <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (IN_VALID && e_ready()) begin
            have_tx <= 1'b1;
            t_acc   <= cyc + 1;
            m_byte  <= IN_DATA;
            m_dc    <= IN_DC;
            m_last  <= IN_LAST;
         end
      end
   end

   // Compare process plus activity counters used by the literal checks.
   int          rise_cnt = 0, cs_low_cnt = 0;
   logic [31:0] mosi_hist = '0;
   logic        prev_lclk = 1'b0;

   always @(negedge SYSTEM_CLK) begin
      check("cs",        CS,        e_cs());
      check("lcd_clk",   LCD_CLK,   e_lclk());
      check("mosi",      MOSI,      e_mosi());
      check("dc",        DC,        m_dc);
      check("reset",     RESET,     cyc >= PULS);
      check("init_done", INIT_DONE, e_init());
      check("in_ready",  IN_READY,  e_ready());
      check("busy",      BUSY,      e_busy());
      if (LCD_CLK && !prev_lclk) begin
         rise_cnt++;
         mosi_hist = {mosi_hist[30:0], MOSI};
      end
      prev_lclk = LCD_CLK;
      if (!CS) cs_low_cnt++;
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge SYSTEM_CLK);
      #2;
   endtask

   task automatic send(input logic [7:0] d, input logic dc, input logic last);
      int n = 0;
      IN_DATA = d; IN_DC = dc; IN_LAST = last; IN_VALID = 1'b1;
      while (!IN_READY && n < 200) begin
         tick_n(1);
         n++;
      end
      check("send_ready", IN_READY, 1'b1);
      tick_n(1);
      IN_VALID = 1'b0;
      IN_DATA  = 8'($urandom);
      IN_DC    = 1'($urandom);
      IN_LAST  = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((BUSY || !IN_READY) && n < 200) begin
         tick_n(1);
         n++;
      end
      check("idle_reached", {BUSY, IN_READY}, 2'b01);
   endtask

   task automatic wait_init();
      int n = 0;
      while (!INIT_DONE && n < 100) begin
         tick_n(1);
         n++;
      end
      check("init_reached", INIT_DONE, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

   initial begin
      int c0, r0;
      IN_DATA = 8'h00; IN_DC = 1'b0; IN_LAST = 1'b0; IN_VALID = 1'b0;
      SYSTEM_RESET_N = 1'b1;
      #1 SYSTEM_RESET_N = 1'b0;
      #1;
      check("rst_cs",   CS,        1'b1);
      check("rst_lclk", LCD_CLK,   1'b0);
      check("rst_mosi", MOSI,      1'b0);
      check("rst_dc",   DC,        1'b0);
      check("rst_pin",  RESET,     1'b0);
      check("rst_rdy",  IN_READY,  1'b0);
      check("rst_init", INIT_DONE, 1'b0);
      check("rst_busy", BUSY,      1'b0);
      tick_n(3);
      SYSTEM_RESET_N = 1'b1;

      // Power-on sequence with a byte offered before INIT_DONE, which must be ignored.
      IN_VALID = 1'b1; IN_DATA = 8'hFF;
      tick_n(9);
      check("pulse_9", RESET, 1'b0);
      tick_n(1);
      check("pulse_10", RESET, 1'b1);
      tick_n(19);
      check("init_29", INIT_DONE, 1'b0);
      IN_VALID = 1'b0;
      tick_n(1);
      check("init_30", INIT_DONE, 1'b1);
      check("ready_30", IN_READY, 1'b1);
      check("pre_init_no_sclk", rise_cnt, 0);
      check("pre_init_cs", CS, 1'b1);

      // Single command byte.
      c0 = cs_low_cnt; r0 = rise_cnt;
      send(CASET, DC_CMD, 1'b1);
      wait_idle();
      check("caset_cs_low", cs_low_cnt - c0, BYTE_CYC);
      check("caset_rises", rise_cnt - r0, 8);
      check("caset_bits", mosi_hist[7:0], CASET);

      // Three bytes back to back under one CS.
      r0 = rise_cnt;
      send(RAMWR, DC_CMD, 1'b0);
      send(8'hFF, DC_DATA, 1'b0);
      send(8'h00, DC_DATA, 1'b1);
      wait_idle();
      check("burst_rises", rise_cnt - r0, 24);
      check("burst_bits", mosi_hist[23:0], 24'h2CFF00);

      // Stall in HOLD for 7 clocks.
      send(8'hA5, DC_DATA, 1'b0);
      while (!IN_READY && rise_cnt < 10_000) tick_n(1);
      c0 = cs_low_cnt; r0 = rise_cnt;
      tick_n(7);
      check("hold_no_sclk", rise_cnt - r0, 0);
      check("hold_cs_low", cs_low_cnt - c0, 7);
      send(8'h3C, DC_DATA, 1'b1);
      wait_idle();
      check("hold_bits", mosi_hist[15:0], 16'hA53C);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         tick_n($urandom_range(0, 4));
         send(8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) || (i == 39));
      end
      wait_idle();

      // Reset in the middle of bit 4 while LCD_CLK is high.
      send(RASET, DC_CMD, 1'b1);
      tick_n(18);
      check("mid_lclk_high", LCD_CLK, 1'b1);
      #1 SYSTEM_RESET_N = 1'b0;
      #1;
      check("abort_cs", CS, 1'b1);
      check("abort_lclk", LCD_CLK, 1'b0);
      r0 = rise_cnt;
      tick_n(3);
      SYSTEM_RESET_N = 1'b1;
      tick_n(5);
      check("repulse_low", RESET, 1'b0);
      tick_n(5);
      check("repulse_high", RESET, 1'b1);
      check("abort_no_sclk", rise_cnt - r0, 0);
      wait_init();
      send(SLPOUT, DC_CMD, 1'b1);
      wait_idle();
      check("post_reset_bits", mosi_hist[7:0], SLPOUT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/st7735_sequencer.md
ST7735_SEQUENCER -- requirements
Module: st7735_sequencer

Interface
REQ-001 SHALL have parameter SPI_DIV, default 2, meaning system clocks per LCD_CLK half-period (legal range 1..255).
REQ-002 SHALL have parameter RESET_PULSE_CYCLES, default 24, meaning system clocks the panel RESET is held low after power-on.
REQ-003 SHALL have parameter RESET_WAIT_CYCLES, default 1440000, meaning system clocks waited after RESET rises before INIT_DONE.
REQ-004 SHALL have parameter CS_GAP_CYCLES, default 2, meaning minimum system clocks CS stays high between transactions.
REQ-005 SHALL have the port SYSTEM_CLK, input, width 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have the port SYSTEM_RESET_N, input, width 1, asynchronous active-low reset.
REQ-007 SHALL have the port IN_DATA, input, width 8, byte to shift out, MSB first.
REQ-008 SHALL have the port IN_DC, input, width 1, driven onto DC for this byte (0 = command, 1 = data).
REQ-009 SHALL have the port IN_LAST, input, width 1, meaning CS deasserts after this byte.
REQ-010 SHALL have the ports IN_VALID (input, width 1) and IN_READY (output, width 1), a byte handshake that accepts a byte on a cycle where both are high.
REQ-011 SHALL have the ports CS, MOSI, DC, LCD_CLK and RESET, all outputs of width 1 and registered: panel chip-select (active low), serial data, data/command select, SPI clock and panel reset (active low).
REQ-012 SHALL have the ports INIT_DONE and BUSY, both outputs of width 1: power-on reset sequence complete, and a transaction in progress (CS low or gap pending).

Function
REQ-013 SHALL implement states RST_PULSE, RST_WAIT, IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP.
REQ-014 RST_PULSE SHALL hold RESET=0 for RESET_PULSE_CYCLES clocks, then drive RESET=1 and go to RST_WAIT.
REQ-015 RST_WAIT SHALL count RESET_WAIT_CYCLES clocks, then set INIT_DONE=1 (sticky until reset) and go to IDLE.
REQ-016 IN_READY SHALL be 1 only in IDLE or HOLD with INIT_DONE=1; IN_VALID before INIT_DONE SHALL be ignored.
REQ-017 On accept, the byte, IN_DC and IN_LAST SHALL be latched; the next cycle SHALL have CS=0, DC=latched IN_DC, MOSI=bit7, LCD_CLK=0, state SHIFT_LO.
REQ-018 SHIFT_LO SHALL last SPI_DIV clocks with LCD_CLK=0; SHIFT_HI SHALL last SPI_DIV clocks with LCD_CLK=1 (SPI mode 0: the panel samples on the rising edge).
REQ-019 MOSI SHALL change only on the SHIFT_HI to SHIFT_LO transition; one byte SHALL occupy exactly 16*SPI_DIV clocks.
REQ-020 After bit0's SHIFT_HI: with latched LAST=1, CS SHALL go 1 and the state SHALL go to GAP; with LAST=0, CS SHALL stay 0 and the state SHALL go to HOLD.
REQ-021 HOLD SHALL keep CS=0, LCD_CLK=0 and DC unchanged indefinitely until the next accept; DC SHALL be updated at that accept.
REQ-022 GAP SHALL keep CS=1 for CS_GAP_CYCLES clocks, then go to IDLE; IN_READY SHALL be 0 throughout.
REQ-023 BUSY SHALL be 1 in SHIFT_LO, SHIFT_HI, HOLD and GAP, and 0 otherwise.
REQ-024 Every counter SHALL be sized with $clog2(param+1) bits and SHALL saturate at its terminal count; none SHALL wrap.
REQ-025 IN_* SHALL be don't-care when IN_READY=0; no byte SHALL be lost or duplicated.

Reset
REQ-026 SYSTEM_RESET_N=0 SHALL immediately force CS=1, LCD_CLK=0, MOSI=0, DC=0, RESET=0, IN_READY=0, INIT_DONE=0, BUSY=0, state RST_PULSE and all counters 0.
REQ-027 A reset during shifting SHALL abort the byte with no further LCD_CLK edges, and the full power-on sequence SHALL rerun after release.

Structure
REQ-028 A shared package st7735_pkg SHALL hold the state encoding, the DC_CMD/DC_DATA constants and the ST7735 command opcodes (SWRESET 0x01, SLPOUT 0x11, DISPON 0x29, CASET 0x2A, RASET 0x2B, RAMWR 0x2C).
REQ-029 The block SHALL contain one sub-module, st7735_tick_gen, a parametrised down-counter producing a one-cycle enable every SPI_DIV clocks, cleared on accept.

Verification (SPI_DIV=2, RESET_PULSE_CYCLES=10, RESET_WAIT_CYCLES=20, CS_GAP_CYCLES=2)
REQ-030 Release reset -> RESET low for 10 clocks then high; INIT_DONE rises 20 clocks later; IN_READY rises with it.
REQ-031 Send 0x2A, DC=0, LAST=1 -> CS low for 32 clocks; MOSI sampled on 8 LCD_CLK rises = 0,0,1,0,1,0,1,0; DC=0; CS high for 2 clocks before IN_READY.
REQ-032 Send 0x2C (DC=0, LAST=0) then 0xFF, 0x00 (DC=1, last with LAST=1) back-to-back -> CS stays low across all 3 bytes; DC flips to 1 only at the second accept; 24 rising edges in total.
REQ-033 Send 0xA5 with IN_VALID held during HOLD, delayed 7 clocks -> LCD_CLK stays 0 and CS stays 0 through the delay; the next byte shifts correctly.
REQ-034 Assert SYSTEM_RESET_N mid-byte at bit 4 -> CS=1 and LCD_CLK=0 in the same cycle; RESET pulses again after release.
REQ-035 Pulse IN_VALID before INIT_DONE -> no LCD_CLK activity and CS stays 1.
